// File: rtl/muldiv_pkg.sv
// Shared encodings for the E-stage multiply/divide sequencer.
// Op codes match the decoder's muldiv field; the FSM has two states.
package muldiv_pkg;

  localparam int CNT_W = 4;

  localparam logic [2:0] MD_NOP   = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // True for the four ops that occupy the unit for several cycles.
  function automatic logic is_multicycle(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// Combinational mul/div datapath operating on the latched op and operands.
// Signed divide works on magnitudes so INT_MIN / -1 wraps to INT_MIN with zero remainder.
module muldiv_core
  import muldiv_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] res_hi_o,
  output logic [31:0] res_lo_o,
  output logic        div0_o
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] s_div;
  logic [31:0] u_div;
  logic [31:0] sq;
  logic [31:0] sr;
  logic [31:0] uq;
  logic [31:0] ur;

  assign prod_s = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
  assign prod_u = {32'd0, a_i} * {32'd0, b_i};

  assign abs_a = a_i[31] ? (~a_i + 32'd1) : a_i;
  assign abs_b = b_i[31] ? (~b_i + 32'd1) : b_i;

  // A zero divisor is replaced by one; the controller discards the result anyway.
  assign s_div = (abs_b == 32'd0) ? 32'd1 : abs_b;
  assign u_div = (b_i == 32'd0) ? 32'd1 : b_i;

  assign sq = abs_a / s_div;
  assign sr = abs_a % s_div;
  assign uq = a_i / u_div;
  assign ur = a_i % u_div;

  assign div0_o = ((op_i == MD_DIV) || (op_i == MD_DIVU)) && (b_i == 32'd0);

  always_comb begin
    res_hi_o = 32'd0;
    res_lo_o = 32'd0;
    case (op_i)
      MD_MULT:  {res_hi_o, res_lo_o} = prod_s;
      MD_MULTU: {res_hi_o, res_lo_o} = prod_u;
      MD_DIV: begin
        res_lo_o = (a_i[31] ^ b_i[31]) ? (~sq + 32'd1) : sq;
        res_hi_o = a_i[31] ? (~sr + 32'd1) : sr;
      end
      MD_DIVU: begin
        res_lo_o = uq;
        res_hi_o = ur;
      end
      default: begin
        res_hi_o = 32'd0;
        res_lo_o = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer owning HI/LO: latches operands, counts out the latency,
// then commits the core result. D-stage users of HI/LO are stalled while a result is pending.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        d_uses_md,
  output logic        start,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        div0;

  muldiv_core u_core (
    .op_i     (op_q),
    .a_i      (a_q),
    .b_i      (b_q),
    .res_hi_o (res_hi),
    .res_lo_o (res_lo),
    .div0_o   (div0)
  );

  assign start = op_valid && is_multicycle(op) && (state_q == ST_IDLE);
  assign busy  = (state_q == ST_RUN);
  // Stalling on start too keeps a back-to-back HI/LO user from slipping into E.
  assign stall = d_uses_md && (busy || start);
  assign hi    = hi_q;
  assign lo    = lo_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          op_d    = op;
          a_d     = rs_val;
          b_d     = rt_val;
          cnt_d   = ((op == MD_MULT) || (op == MD_MULTU)) ? MUL_CNT : DIV_CNT;
        end else if (op_valid && (op == MD_MTHI)) begin
          hi_d = rs_val;
        end else if (op_valid && (op == MD_MTLO)) begin
          lo_d = rs_val;
        end
      end
      ST_RUN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = ST_IDLE;
          if (!div0) begin
            hi_d = res_hi;
            lo_d = res_lo;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= MD_NOP;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: directed literal cases plus randomized issue against a
// cycle-level reference that tracks remaining busy cycles and the pending HI/LO result.
module tb_muldiv_ctrl;

  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        op_valid = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] rs_val = 32'd0;
  logic [31:0] rt_val = 32'd0;
  logic        d_uses_md = 1'b0;
  logic        start;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int vectors = 0;
  int miscompares = 0;

  muldiv_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .op_valid  (op_valid),
    .op        (op),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .d_uses_md (d_uses_md),
    .start     (start),
    .busy      (busy),
    .stall     (stall),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Reference arithmetic in 64-bit integers; bit 64 says whether HI/LO get written.
  function automatic logic [64:0] ref_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, q, r, p;
    longint unsigned ua, ub, uq, ur, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      3'd1: begin p = sa * sb; return {1'b1, p[63:0]}; end
      3'd2: begin up = ua * ub; return {1'b1, up[63:0]}; end
      3'd3: begin
        if (b == 32'd0) return 65'd0;
        q = sa / sb;
        r = sa % sb;
        return {1'b1, r[31:0], q[31:0]};
      end
      3'd4: begin
        if (b == 32'd0) return 65'd0;
        uq = ua / ub;
        ur = ua % ub;
        return {1'b1, ur[31:0], uq[31:0]};
      end
      default: return 65'd0;
    endcase
  endfunction

  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  logic [64:0] m_pend = 65'd0;
  int          m_rem = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_hi   <= 32'd0;
      m_lo   <= 32'd0;
      m_pend <= 65'd0;
      m_rem  <= 0;
    end else if (m_rem > 0) begin
      if (op_valid) begin
        vectors++;
        miscompares++;
        $display("FAIL illegal_issue: op %0d issued while busy, %0d cycles left", op, m_rem);
      end
      m_rem <= m_rem - 1;
      if (m_rem == 1 && m_pend[64]) begin
        m_hi <= m_pend[63:32];
        m_lo <= m_pend[31:0];
      end
    end else if (op_valid) begin
      case (op)
        3'd1, 3'd2: begin m_rem <= MUL_LAT; m_pend <= ref_op(op, rs_val, rt_val); end
        3'd3, 3'd4: begin m_rem <= DIV_LAT; m_pend <= ref_op(op, rs_val, rt_val); end
        3'd5: m_hi <= rs_val;
        3'd6: m_lo <= rs_val;
        default: ;
      endcase
    end
  end

  logic e_busy, e_start, e_stall;

  always @(negedge clk) begin
    e_busy  = (m_rem > 0);
    e_start = op_valid && (op >= 3'd1) && (op <= 3'd4) && !e_busy;
    e_stall = d_uses_md && (e_busy || e_start);
    chk("start", 32'(start), 32'(e_start));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("stall", 32'(stall), 32'(e_stall));
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    op_valid = 1'b1; op = o; rs_val = a; rt_val = b;
    @(posedge clk); #1;
    op_valid = 1'b0; op = 3'd0; rs_val = $urandom; rt_val = $urandom;
  endtask

  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo, input int lat);
    int n;
    bit done;
    issue(o, a, b);
    n = 0;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (busy) n++;
      else done = 1'b1;
    end
    chk({name, "_done"}, 32'(done), 32'd1);
    chk({name, "_lat"}, 32'(n), 32'(lat));
    chk({name, "_hi"}, hi, exp_hi);
    chk({name, "_lo"}, lo, exp_lo);
    chk({name, "_model_hi"}, m_hi, exp_hi);
    chk({name, "_model_lo"}, m_lo, exp_lo);
  endtask

  initial begin
    int  n;
    bit  done;
    int  sel;

    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    run_op("mult_neg", 3'd1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, MUL_LAT);
    run_op("multu_max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_LAT);
    run_op("div_neg", 3'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT);
    run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, DIV_LAT);

    // Stall held from the accept cycle through the last busy cycle.
    @(posedge clk); #1;
    op_valid = 1'b1; op = 3'd3; rs_val = 32'd100; rt_val = 32'd7; d_uses_md = 1'b1;
    @(negedge clk);
    chk("stall_accept", 32'(stall), 32'd1);
    chk("start_accept", 32'(start), 32'd1);
    @(posedge clk); #1;
    op_valid = 1'b0; op = 3'd0;
    n = 0;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (stall) n++;
      else done = 1'b1;
    end
    chk("stall_done", 32'(done), 32'd1);
    chk("stall_cycles", 32'(n), 32'(DIV_LAT));
    chk("stall_div_hi", hi, 32'd2);
    chk("stall_div_lo", lo, 32'd14);
    d_uses_md = 1'b0;

    @(posedge clk); #1;
    op_valid = 1'b1; op = 3'd5; rs_val = 32'h1234;
    @(posedge clk); #1;
    op = 3'd6; rs_val = 32'h5678;
    @(posedge clk); #1;
    op_valid = 1'b0; op = 3'd0;
    @(negedge clk);
    chk("mthi", hi, 32'h1234);
    chk("mtlo", lo, 32'h5678);
    chk("mt_busy", 32'(busy), 32'd0);
    run_op("divu_zero", 3'd4, 32'hDEAD_BEEF, 32'd0, 32'h1234, 32'h5678, DIV_LAT);

    // Reset in cycle T+4 of a divide: cleared at once, nothing written afterwards.
    issue(3'd4, 32'd1000, 32'd3);
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_hi", hi, 32'd0);
    chk("post_rst_lo", lo, 32'd0);

    repeat (600) begin
      @(posedge clk); #1;
      d_uses_md = 1'($urandom_range(0, 1));
      rs_val = $urandom;
      rt_val = $urandom;
      if (m_rem == 0 && $urandom_range(0, 2) == 0) begin
        op_valid = 1'b1;
        op = 3'($urandom_range(0, 7));
        sel = $urandom_range(0, 7);
        if (sel == 0) rt_val = 32'd0;
        else if (sel == 1) begin rs_val = 32'h8000_0000; rt_val = 32'hFFFF_FFFF; end
        else if (sel == 2) rt_val = 32'($urandom_range(1, 9)) * (($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'd1);
      end else begin
        op_valid = 1'b0;
      end
    end
    @(posedge clk); #1;
    op_valid = 1'b0;
    d_uses_md = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
